shot_pool: RTL

Parametrised projectile manager for the duck-hunter game: holds up to SLOTS simultaneous shots, launches a new shot when the trigger is released, moves every live shot upward once per step tick, and retires shots on reaching the top or on a hit from the collision logic. Sits between the trigger/crosshair logic and the VGA renderer and collision checker. It exposes a free-running slot scan so downstream logic can read one slot per clock.

---
 rtl/duck_pkg.sv | 22 ++
 rtl/shot_free_finder.sv | 23 ++
 rtl/shot_pool.sv | 138 +++++++++++++
 3 files changed

// File: rtl/duck_pkg.sv
// Shared constants and types for the duck-hunter game: screen geometry,
// shot launch/kill rows and the shot slot record.
package duck_pkg;

    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int SHOT_H      = 10;

    // Shots launch just above the gun sprite and may travel until fully off-screen.
    localparam int SPAWN_Y_DEF = SCREEN_H - 56;
    localparam int KILL_Y_DEF  = -SHOT_H;

    localparam int SHOT_XW     = $clog2(SCREEN_W);
    localparam int SHOT_YW     = $clog2(SCREEN_H) + 1;

    typedef struct packed {
        logic                      valid;
        logic [SHOT_XW-1:0]        x;
        logic signed [SHOT_YW-1:0] y;
    } shot_t;

endpackage

// File: rtl/shot_free_finder.sv
// Lowest-index free slot finder: priority encoder over the slot valid bits.
module shot_free_finder #(
    parameter int SLOTS = 8,
    parameter int IW    = $clog2(SLOTS)
) (
    input  logic [SLOTS-1:0] valid,
    output logic [IW-1:0]    free_idx,
    output logic             any_free
);

    // Scan from the top down so the lowest free index is the last one written.
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_idx = IW'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shot_pool.sv
// Projectile pool: launches shots on trigger release, moves live shots up
// once per step tick, retires them on hit or leaving the top, and scans slots.
module shot_pool
    import duck_pkg::*;
#(
    parameter int SLOTS    = 8,
    parameter int IW       = $clog2(SLOTS),
    parameter int CW       = $clog2(SLOTS + 1),
    parameter int XW       = SHOT_XW,
    parameter int YW       = SHOT_YW,
    parameter int SPAWN_Y  = SPAWN_Y_DEF,
    parameter int KILL_Y   = KILL_Y_DEF,
    parameter int STEP_DIV = 60000,
    parameter int STEP_PX  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fire,
    input  logic [XW-1:0]        pos_x,
    input  logic                 hit_valid,
    input  logic [IW-1:0]        hit_slot,
    output logic [IW-1:0]        scan_slot,
    output logic                 scan_valid,
    output logic [XW-1:0]        scan_x,
    output logic signed [YW-1:0] scan_y,
    output logic [CW-1:0]        live_count,
    output logic                 full,
    output logic                 shot_fired,
    output logic                 shot_dropped
);

    localparam int PW = $clog2(STEP_DIV);
    localparam logic signed [YW:0]   KILL_EXT = (YW+1)'(KILL_Y);
    localparam logic signed [YW:0]   STEP_EXT = (YW+1)'(STEP_PX);
    localparam logic signed [YW-1:0] SPAWN_V  = YW'(SPAWN_Y);

    logic                 fire_q, fire_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [IW-1:0]        scan_q, scan_d;
    logic                 fired_q, fired_d;
    logic                 dropped_q, dropped_d;
    logic [SLOTS-1:0]     valid_q, valid_d;
    logic [XW-1:0]        x_q [SLOTS];
    logic [XW-1:0]        x_d [SLOTS];
    logic signed [YW-1:0] y_q [SLOTS];
    logic signed [YW-1:0] y_d [SLOTS];

    logic                 tick;
    logic                 launch_req;
    logic [IW-1:0]        free_idx;
    logic                 any_free;
    logic [CW-1:0]        live_cnt;

    shot_free_finder #(
        .SLOTS (SLOTS),
        .IW    (IW)
    ) u_free_finder (
        .valid    (valid_q),
        .free_idx (free_idx),
        .any_free (any_free)
    );

    always_comb begin
        logic signed [YW:0] stepped;
        fire_d     = fire;
        launch_req = fire_q & ~fire;
        tick       = (presc_q == PW'(STEP_DIV - 1));
        presc_d    = tick ? '0 : presc_q + 1'b1;
        scan_d     = (scan_q == IW'(SLOTS - 1)) ? '0 : scan_q + 1'b1;
        fired_d    = launch_req & any_free;
        dropped_d  = launch_req & ~any_free;
        valid_d    = valid_q;
        for (int i = 0; i < SLOTS; i++) begin
            x_d[i]  = x_q[i];
            y_d[i]  = y_q[i];
            stepped = $signed({y_q[i][YW-1], y_q[i]}) - STEP_EXT;
            // A hit outranks the step; a free slot can only be claimed by a launch.
            if (valid_q[i]) begin
                if (hit_valid && (hit_slot == IW'(i))) begin
                    valid_d[i] = 1'b0;
                end else if (tick) begin
                    if (stepped >= KILL_EXT) begin
                        y_d[i] = stepped[YW-1:0];
                    end else begin
                        valid_d[i] = 1'b0;
                    end
                end
            end else if (fired_d && (free_idx == IW'(i))) begin
                valid_d[i] = 1'b1;
                x_d[i]     = pos_x;
                y_d[i]     = SPAWN_V;
            end
        end
    end

    always_comb begin
        live_cnt = '0;
        for (int i = 0; i < SLOTS; i++) begin
            live_cnt = live_cnt + CW'(valid_q[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fire_q    <= 1'b0;
            presc_q   <= '0;
            scan_q    <= '0;
            fired_q   <= 1'b0;
            dropped_q <= 1'b0;
            valid_q   <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            fire_q    <= fire_d;
            presc_q   <= presc_d;
            scan_q    <= scan_d;
            fired_q   <= fired_d;
            dropped_q <= dropped_d;
            valid_q   <= valid_d;
            for (int i = 0; i < SLOTS; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
        end
    end

    assign scan_slot    = scan_q;
    assign scan_valid   = valid_q[scan_q];
    assign scan_x       = x_q[scan_q];
    assign scan_y       = y_q[scan_q];
    assign live_count   = live_cnt;
    assign full         = (live_cnt == CW'(SLOTS));
    assign shot_fired   = fired_q;
    assign shot_dropped = dropped_q;

endmodule
